hilo_unit: RTL and testbench

HILO_UNIT -- requirements
Module: hilo_unit

---
 rtl/hilo_pkg.sv | 28 ++
 rtl/hilo_lat_counter.sv | 28 ++
 rtl/hilo_unit.sv | 121 ++++++++++++
 tb/tb_hilo_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared constants and types for the HI/LO multiply-result register block.
package hilo_pkg;

   localparam int unsigned CNT_W           = 6;
   localparam int unsigned DATA_W          = 32;
   localparam int unsigned MUL_LAT_DEFAULT = 32;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT    = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;

   // rd_sel encoding
   localparam logic SEL_LO = 1'b0;
   localparam logic SEL_HI = 1'b1;

   // Upstream product as delivered on prod_in: {hi, lo}
   typedef struct packed {
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
   } hilo_t;

   // Counter reload value: two cycles are spent in the IDLE->WAIT and CAPTURE transitions
   function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
      return CNT_W'(lat - 32'd2);
   endfunction

endpackage

// File: rtl/hilo_lat_counter.sv
// Loadable down-counter tracking the remaining multiplier latency.
module hilo_lat_counter
   import hilo_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero_c
);

   logic [CNT_W-1:0] count;

   // Load has priority over decrement; decrement saturates at zero
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero_c = (count == '0);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register file: captures multiplier products and serves MFHI/MFLO/MTHI/MTLO.
module hilo_unit
   import hilo_pkg::*;
#(
   parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        mul_start,
   input  logic [63:0] prod_in,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wr_data,
   input  logic        rd_req,
   input  logic        rd_sel,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        stall,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MUL_LAT);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       cnt_load;
   logic       cnt_dec;
   logic       cnt_zero_c;
   logic       capture;
   hilo_t      prod;

   assign prod  = prod_in;
   assign busy  = (state != ST_IDLE);
   assign stall = (rd_req | mthi | mtlo) & (busy | mul_start);

   hilo_lat_counter u_lat_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (LAT_LOAD),
      .dec      (cnt_dec),
      .zero_c   (cnt_zero_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and counter control; a new mul_start always restarts the latency window
   always_comb begin
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      capture   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mul_start) begin
               state_nxt = ST_WAIT;
               cnt_load  = 1'b1;
            end
         end
         ST_WAIT: begin
            if (mul_start) begin
               cnt_load = 1'b1;
            end else if (cnt_zero_c) begin
               state_nxt = ST_CAPTURE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_CAPTURE: begin
            capture = 1'b1;
            if (mul_start) begin
               state_nxt = ST_WAIT;
               cnt_load  = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // HI/LO write port: product capture, or MTHI/MTLO when not stalled
   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (capture) begin
         hi <= prod.hi;
         lo <= prod.lo;
      end else if (!stall) begin
         if (mthi) hi <= wr_data;
         if (mtlo) lo <= wr_data;
      end
   end

   // Read port samples the pre-write HI/LO, giving read-before-write ordering
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         if (rd_req && !stall) begin
            rd_data  <= (rd_sel == SEL_LO) ? lo : hi;
            rd_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit with a read-result scoreboard.
module tb_hilo_unit;
   import hilo_pkg::*;

   localparam int MUL_LAT = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        mul_start;
   logic [63:0] prod_in;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wr_data;
   logic        rd_req;
   logic        rd_sel;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        stall;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] sb[$];
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   always #5 clk = ~clk;

   hilo_unit #(.MUL_LAT(MUL_LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .mul_start (mul_start),
      .prod_in   (prod_in),
      .mthi      (mthi),
      .mtlo      (mtlo),
      .wr_data   (wr_data),
      .rd_req    (rd_req),
      .rd_sel    (rd_sel),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .stall     (stall),
      .busy      (busy),
      .hi        (hi),
      .lo        (lo)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] junk();
      return {$urandom(), $urandom()};
   endfunction

   // Scoreboard: every rd_valid pulse must match the oldest expected read
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (sb.size() == 0) check("rd_unexpected", 64'(rd_valid), 64'd0);
         else                check("rd_data", 64'(rd_data), 64'(sb.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Multiply whose product is only presented in the capture cycle
   task automatic mul_run(input logic [63:0] p, input string tag);
      int          bc;
      logic [31:0] ohi;
      logic [31:0] olo;
      bc  = 0;
      ohi = m_hi;
      olo = m_lo;
      mul_start = 1'b1;
      prod_in   = junk();
      step();
      mul_start = 1'b0;
      for (int k = 1; k <= MUL_LAT + 4; k++) begin
         prod_in = (k == MUL_LAT) ? p : junk();
         bc += int'(busy);
         if (k == MUL_LAT) begin
            check({tag, "_hi_before"}, 64'(hi), 64'(ohi));
            check({tag, "_lo_before"}, 64'(lo), 64'(olo));
         end
         if (k == MUL_LAT + 1) begin
            check({tag, "_hi"}, 64'(hi), 64'(p[63:32]));
            check({tag, "_lo"}, 64'(lo), 64'(p[31:0]));
         end
         step();
      end
      check({tag, "_busy_cycles"}, 64'(bc), 64'(MUL_LAT));
      m_hi = p[63:32];
      m_lo = p[31:0];
   endtask

   initial begin
      int          sc;
      int          bc;
      logic [63:0] p3;
      logic [63:0] p4;
      logic [63:0] p6;
      logic [63:0] decoy;

      reset = 1'b1; mul_start = 1'b0; prod_in = '0; mthi = 1'b0; mtlo = 1'b0;
      wr_data = '0; rd_req = 1'b0; rd_sel = SEL_LO;
      m_hi = '0; m_lo = '0;
      step();
      step();
      reset = 1'b0;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_rd_data", 64'(rd_data), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);

      // 3*5 and 0xFFFFFFFF squared
      mul_run(64'd15, "mul15");
      mul_run(64'hFFFFFFFE_00000001, "mulsq");

      // MFHI issued 5 cycles after mul_start stalls until capture completes
      p3 = 64'h12345678_9ABCDEF0;
      sc = 0;
      mul_start = 1'b1;
      prod_in   = junk();
      step();
      mul_start = 1'b0;
      for (int k = 1; k <= MUL_LAT + 6; k++) begin
         prod_in = (k == MUL_LAT) ? p3 : junk();
         rd_req  = (k >= 5) && (k <= MUL_LAT + 1);
         rd_sel  = SEL_HI;
         #1;
         if (k >= 5 && k <= MUL_LAT + 1) sc += int'(stall);
         if (k == 5) check("rdst_stall_first", 64'(stall), 64'd1);
         if (k == MUL_LAT + 1) begin
            check("rdst_stall_drop", 64'(stall), 64'd0);
            sb.push_back(p3[63:32]);
         end
         if (k == MUL_LAT + 2) check("rdst_valid", 64'(rd_valid), 64'd1);
         if (k == MUL_LAT + 3) check("rdst_valid_pulse", 64'(rd_valid), 64'd0);
         step();
      end
      rd_req = 1'b0;
      check("rdst_stall_cycles", 64'(sc), 64'(MUL_LAT - 4));
      m_hi = p3[63:32];
      m_lo = p3[31:0];

      // MTHI then MFHI in idle
      mthi = 1'b1; wr_data = 32'hDEADBEEF;
      #1;
      check("mthi_stall", 64'(stall), 64'd0);
      step();
      mthi = 1'b0;
      m_hi = 32'hDEADBEEF;
      check("mthi_hi", 64'(hi), 64'(m_hi));
      check("mthi_lo_kept", 64'(lo), 64'(m_lo));
      rd_req = 1'b1; rd_sel = SEL_HI;
      sb.push_back(m_hi);
      step();
      rd_req = 1'b0;
      check("mfhi_valid", 64'(rd_valid), 64'd1);
      step();
      check("mfhi_valid_pulse", 64'(rd_valid), 64'd0);

      // MFLO together with MTLO returns the old LO
      rd_req = 1'b1; rd_sel = SEL_LO; mtlo = 1'b1; wr_data = 32'h11111111;
      sb.push_back(m_lo);
      step();
      rd_req = 1'b0; mtlo = 1'b0;
      m_lo = 32'h11111111;
      check("rbw_lo", 64'(lo), 64'(m_lo));
      step();

      // MTHI and MTLO together write both
      mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hA5A5A5A5;
      step();
      mthi = 1'b0; mtlo = 1'b0;
      m_hi = 32'hA5A5A5A5; m_lo = 32'hA5A5A5A5;
      check("mtboth_hi", 64'(hi), 64'(m_hi));
      check("mtboth_lo", 64'(lo), 64'(m_lo));

      // MTHI alongside mul_start is stalled and dropped
      p4 = 64'h0F0F0F0F_F0F0F0F0;
      mul_start = 1'b1; mthi = 1'b1; wr_data = 32'h0;
      #1;
      check("mthi_mul_stall", 64'(stall), 64'd1);
      step();
      mul_start = 1'b0; mthi = 1'b0;
      check("mthi_mul_dropped", 64'(hi), 64'(m_hi));
      for (int k = 1; k <= MUL_LAT + 1; k++) begin
         prod_in = (k == MUL_LAT) ? p4 : junk();
         step();
      end
      m_hi = p4[63:32]; m_lo = p4[31:0];
      check("p4_hi", 64'(hi), 64'(m_hi));
      check("p4_lo", 64'(lo), 64'(m_lo));

      // Reset 10 cycles into WAIT discards the product
      mul_start = 1'b1; prod_in = junk();
      step();
      mul_start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         prod_in = junk();
         step();
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      check("wrst_busy", 64'(busy), 64'd0);
      check("wrst_hi", 64'(hi), 64'd0);
      check("wrst_lo", 64'(lo), 64'd0);
      check("wrst_rd_data", 64'(rd_data), 64'd0);
      bc = 0;
      for (int k = 1; k <= MUL_LAT + 4; k++) begin
         prod_in = 64'hCAFEF00D_0BADBEEF;
         bc += int'(busy);
         step();
      end
      check("wrst_busy_after", 64'(bc), 64'd0);
      check("wrst_hi_after", 64'(hi), 64'd0);
      check("wrst_lo_after", 64'(lo), 64'd0);

      // Second mul_start 10 cycles in: only the newer product lands
      p6    = 64'h76543210_FEDCBA98;
      decoy = 64'h55555555_AAAAAAAA;
      bc = 0;
      mul_start = 1'b1; prod_in = junk();
      step();
      for (int k = 1; k <= MUL_LAT + 14; k++) begin
         mul_start = (k == 10);
         prod_in   = (k == 10 + MUL_LAT) ? p6 : (k == MUL_LAT) ? decoy : junk();
         bc += int'(busy);
         if (k == MUL_LAT + 1) begin
            check("remul_hi_old", 64'(hi), 64'(m_hi));
            check("remul_lo_old", 64'(lo), 64'(m_lo));
         end
         if (k == 10 + MUL_LAT) check("remul_hi_before", 64'(hi), 64'(m_hi));
         if (k == 10 + MUL_LAT + 1) begin
            check("remul_hi", 64'(hi), 64'(p6[63:32]));
            check("remul_lo", 64'(lo), 64'(p6[31:0]));
         end
         step();
      end
      mul_start = 1'b0;
      check("remul_busy_cycles", 64'(bc), 64'(10 + MUL_LAT));

      step();
      step();
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
